// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: one power-of-two conditional shift stage per cycle (SLL/SRL/SRA/ROR).
// Ports: in_* request (valid/ready), out_* result (valid/ready), flush abort, busy and constant ALU flags.
// Latency: 1 cycle for shamt==0, else 2 + index of the highest set shamt bit; the result is held while out_ready is low.
module shift_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SH_W-1:0]  in_shamt,
    input  logic [1:0]       in_op,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0]      OP_SLL  = 2'b00;
    localparam logic [1:0]      OP_SRL  = 2'b01;
    localparam logic [1:0]      OP_SRA  = 2'b10;
    localparam logic [SH_W-1:0] K_LAST  = SH_W'(SH_W - 1);
    localparam logic [SH_W:0]   WIDTH_L = (SH_W + 1)'(WIDTH);

    state_t           state_q, state_d;
    logic [SH_W-1:0]  k;
    logic [SH_W-1:0]  shamt_q;
    logic [1:0]       op_q;
    logic             sign_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    logic [SH_W:0]    amt;
    logic [SH_W-1:0]  hi_bits;
    logic             last;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] step;
    logic             accept;

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_result = result_q;
    assign out_zero   = zero_q;
    assign out_carry  = 1'b0;
    assign out_ovf    = 1'b0;

    // A flush in IDLE blocks the accept even though in_ready is high.
    assign accept = in_valid && in_ready && !flush;

    // Stage k shifts by 2^k; the sequence ends once no higher shamt bit is set.
    assign amt     = (SH_W + 1)'(1) << k;
    assign hi_bits = shamt_q >> k;
    assign last    = (k == K_LAST) || ((hi_bits >> 1) == '0);

    always_comb begin
        shifted = result_q;
        case (op_q)
            OP_SLL:  shifted = result_q << amt;
            OP_SRL:  shifted = result_q >> amt;
            // Fill from the sign captured at accept, not the current MSB.
            OP_SRA:  shifted = (result_q >> amt) |
                               (sign_q ? ~({WIDTH{1'b1}} >> amt) : '0);
            default: shifted = (result_q >> amt) | (result_q << (WIDTH_L - amt));
        endcase
        step = shamt_q[k] ? shifted : result_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (in_shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result only moves on accept or in a non-flushed SHIFT cycle, so it stays put in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            shamt_q  <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
            k        <= '0;
        end else if (state_q == IDLE && accept) begin
            result_q <= in_a;
            zero_q   <= (in_a == '0);
            shamt_q  <= in_shamt;
            op_q     <= in_op;
            sign_q   <= in_a[WIDTH-1];
            k        <= '0;
        end else if (state_q == SHIFT && !flush) begin
            result_q <= step;
            zero_q   <= (step == '0);
            if (!last) begin
                k <= k + 1'b1;
            end
        end
    end

endmodule
